// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller:
// opcodes, FSM states, mux-select / ALUOp encodings and the control bundle.
// ALU_Control decodes funct using the same aluop_e encoding.
package cpu_ctrl_pkg;

    // Opcodes as they appear in IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [1:0] {
        SRCB_RT     = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alusrcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_e;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_ERROR  = 4'd13
    } state_e;

    // Datapath control bundle driven by the output decoder
    typedef struct packed {
        logic     pc_write;
        logic     pc_write_cond;
        logic     i_or_d;
        logic     mem_read;
        logic     mem_write;
        logic     ir_write;
        logic     mem_to_reg;
        logic     reg_dst;
        logic     reg_write;
        logic     alu_src_a;
        alusrcb_e alu_src_b;
        aluop_e   alu_op;
        pcsrc_e   pc_source;
        logic     retire;
        logic     err;
    } ctrl_t;

    // States that wait on the memory ready handshake
    function automatic logic is_mem_wait(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait timer: counts not-ready cycles, flags the last allowed one.
// Ports: clk/rst, clr (restart), inc (count one cycle), timeout (count at limit).
module mc_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    localparam int TW = $clog2(WAIT_MAX + 1);
    localparam logic [TW-1:0] LAST = TW'(WAIT_MAX - 1);

    logic [TW-1:0] cnt;

    // timeout means WAIT_MAX-1 not-ready cycles are already behind us,
    // so the current cycle is the final one that may still see ready.
    assign timeout = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !timeout) begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM for the multicycle MIPS datapath with ready-handshake
// memory, wait timeout and a retired-instruction counter.
// Ports: clk_i, rst_i (async high), start_i, Op_i[5:0], mem_ready_i in;
//        datapath controls (PCWrite_o .. PCSource_o), retire_o,
//        instr_cnt_o[CNT_W-1:0], err_o out.
module multicycle_main_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [5:0]       Op_i,
    input  logic             mem_ready_i,
    output logic             PCWrite_o,
    output logic             PCWriteCond_o,
    output logic             IorD_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             IRWrite_o,
    output logic             MemtoReg_o,
    output logic             RegDst_o,
    output logic             RegWrite_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [1:0]       ALUOp_o,
    output logic [1:0]       PCSource_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic             err_o
);

    state_e     state;
    state_e     state_nxt;
    state_e     retire_nxt;
    ctrl_t      ctrl;
    logic       mem_wait;
    logic       timeout;
    logic [CNT_W-1:0] instr_cnt;

    assign mem_wait = is_mem_wait(state);

    // Timer restarts whenever we are outside a wait state or the access
    // completes, so every entry into a wait state starts from zero.
    mc_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (!mem_wait || mem_ready_i),
        .inc     (mem_wait && !mem_ready_i),
        .timeout (timeout)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // After completing an instruction, continue only while run is enabled
    assign retire_nxt = start_i ? S_FETCH : S_IDLE;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start_i) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready_i)  state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_ERROR;
            end
            S_DECODE: begin
                case (Op_i)
                    OP_RTYPE: state_nxt = S_EXEC;
                    OP_LW,
                    OP_SW:    state_nxt = S_MEMADR;
                    OP_BEQ:   state_nxt = S_BRANCH;
                    OP_J:     state_nxt = S_JUMP;
                    OP_ADDI:  state_nxt = S_ADDIEX;
                    default:  state_nxt = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                state_nxt = (Op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready_i)  state_nxt = S_MEMWB;
                else if (timeout) state_nxt = S_ERROR;
            end
            S_MEMWR: begin
                if (mem_ready_i)  state_nxt = retire_nxt;
                else if (timeout) state_nxt = S_ERROR;
            end
            S_EXEC:   state_nxt = S_RWB;
            S_ADDIEX: state_nxt = S_ADDIWB;
            S_MEMWB,
            S_RWB,
            S_BRANCH,
            S_JUMP,
            S_ADDIWB: state_nxt = retire_nxt;
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_ERROR;
        endcase
    end

    // Output decode (Moore, except the ready-qualified fetch/store strobes)
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_IDLE: ;
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready_i;
                ctrl.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR,
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.retire    = mem_ready_i;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.retire        = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.retire    = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_ERROR: begin
                ctrl.err = 1'b1;
            end
            default: ;
        endcase
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_cnt <= '0;
        end else if (ctrl.retire) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    assign PCWrite_o     = ctrl.pc_write;
    assign PCWriteCond_o = ctrl.pc_write_cond;
    assign IorD_o        = ctrl.i_or_d;
    assign MemRead_o     = ctrl.mem_read;
    assign MemWrite_o    = ctrl.mem_write;
    assign IRWrite_o     = ctrl.ir_write;
    assign MemtoReg_o    = ctrl.mem_to_reg;
    assign RegDst_o      = ctrl.reg_dst;
    assign RegWrite_o    = ctrl.reg_write;
    assign ALUSrcA_o     = ctrl.alu_src_a;
    assign ALUSrcB_o     = ctrl.alu_src_b;
    assign ALUOp_o       = ctrl.alu_op;
    assign PCSource_o    = ctrl.pc_source;
    assign retire_o      = ctrl.retire;
    assign instr_cnt_o   = instr_cnt;
    // ERROR is absorbing until reset, so the flag is sticky by construction
    assign err_o         = ctrl.err;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Directed testbench for multicycle_main_ctrl (WAIT_MAX=4).
// Control outputs are packed into one vector and compared per cycle.
module tb_multicycle_main_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  op;
    logic        ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic        retire, err;
    logic [31:0] instr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // {PCW,PCWC,IorD,MR,MW,IRW}_{MtR,RD,RW,SA}_{SB,OP,PS}_{ret,err}
    logic [17:0] ctl;
    assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_source, retire, err};

    localparam logic [17:0] E_IDLE    = 18'b000000_0000_000000_00;
    localparam logic [17:0] E_FETCH_N = 18'b000100_0000_010000_00;
    localparam logic [17:0] E_FETCH_R = 18'b100101_0000_010000_00;
    localparam logic [17:0] E_DECODE  = 18'b000000_0000_110000_00;
    localparam logic [17:0] E_MEMADR  = 18'b000000_0001_100000_00;
    localparam logic [17:0] E_MEMRD   = 18'b001100_0000_000000_00;
    localparam logic [17:0] E_MEMWB   = 18'b000000_1010_000000_10;
    localparam logic [17:0] E_MEMWR_N = 18'b001010_0000_000000_00;
    localparam logic [17:0] E_EXEC    = 18'b000000_0001_001000_00;
    localparam logic [17:0] E_RWB     = 18'b000000_0110_000000_10;
    localparam logic [17:0] E_BRANCH  = 18'b010000_0001_000101_10;
    localparam logic [17:0] E_JUMP    = 18'b100000_0000_000010_10;
    localparam logic [17:0] E_ADDIEX  = 18'b000000_0001_100000_00;
    localparam logic [17:0] E_ADDIWB  = 18'b000000_0010_000000_10;
    localparam logic [17:0] E_ERROR   = 18'b000000_0000_000000_01;

    multicycle_main_ctrl #(
        .WAIT_MAX (4),
        .CNT_W    (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .Op_i          (op),
        .mem_ready_i   (ready),
        .PCWrite_o     (pc_write),
        .PCWriteCond_o (pc_write_cond),
        .IorD_o        (i_or_d),
        .MemRead_o     (mem_read),
        .MemWrite_o    (mem_write),
        .IRWrite_o     (ir_write),
        .MemtoReg_o    (mem_to_reg),
        .RegDst_o      (reg_dst),
        .RegWrite_o    (reg_write),
        .ALUSrcA_o     (alu_src_a),
        .ALUSrcB_o     (alu_src_b),
        .ALUOp_o       (alu_op),
        .PCSource_o    (pc_source),
        .retire_o      (retire),
        .instr_cnt_o   (instr_cnt),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive this cycle's inputs, check outputs, advance past next edge
    task automatic cyc(input string tag, input logic st, input logic rdy,
                       input logic [5:0] o, input logic [17:0] exp);
        start = st;
        ready = rdy;
        op    = o;
        #1;
        check(tag, 32'(ctl), 32'(exp));
        @(posedge clk);
        #2;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 6'b0;
        ready = 1'b0;
        #1;
        check("rst_ctl", 32'(ctl), 32'(E_IDLE));
        check("rst_cnt", instr_cnt, 32'd0);
        release_reset();

        // Idle with start low
        for (int i = 0; i < 5; i++) cyc("idle", 1'b0, 1'b0, 6'b0, E_IDLE);
        check("idle_cnt", instr_cnt, 32'd0);

        // R-type, zero-wait memory
        cyc("r_idle",   1'b1, 1'b1, 6'b000000, E_IDLE);
        cyc("r_fetch",  1'b1, 1'b1, 6'b000000, E_FETCH_R);
        cyc("r_decode", 1'b1, 1'b1, 6'b000000, E_DECODE);
        cyc("r_exec",   1'b1, 1'b1, 6'b000000, E_EXEC);
        check("r_cnt0", instr_cnt, 32'd0);
        cyc("r_rwb",    1'b1, 1'b1, 6'b000000, E_RWB);
        check("r_cnt1", instr_cnt, 32'd1);

        // lw with 3 not-ready cycles, ready on the 4th (= WAIT_MAX)
        cyc("lw_fetch",  1'b1, 1'b1, 6'b100011, E_FETCH_R);
        cyc("lw_decode", 1'b1, 1'b1, 6'b100011, E_DECODE);
        cyc("lw_memadr", 1'b1, 1'b1, 6'b100011, E_MEMADR);
        for (int i = 0; i < 3; i++)
            cyc("lw_memrd_w", 1'b1, 1'b0, 6'b100011, E_MEMRD);
        cyc("lw_memrd_r", 1'b1, 1'b1, 6'b100011, E_MEMRD);
        cyc("lw_memwb",   1'b1, 1'b1, 6'b100011, E_MEMWB);
        check("lw_cnt", instr_cnt, 32'd2);

        // sw that never completes -> timeout
        cyc("sw_fetch",  1'b1, 1'b1, 6'b101011, E_FETCH_R);
        cyc("sw_decode", 1'b1, 1'b1, 6'b101011, E_DECODE);
        cyc("sw_memadr", 1'b1, 1'b0, 6'b101011, E_MEMADR);
        for (int i = 0; i < 4; i++)
            cyc("sw_memwr", 1'b1, 1'b0, 6'b101011, E_MEMWR_N);
        for (int i = 0; i < 3; i++)
            cyc("sw_error", 1'b1, 1'b1, 6'b101011, E_ERROR);
        check("sw_cnt", instr_cnt, 32'd2);

        // Reset acts without waiting for a clock edge
        rst = 1'b1;
        #1;
        check("rst2_ctl", 32'(ctl), 32'(E_IDLE));
        check("rst2_cnt", instr_cnt, 32'd0);
        release_reset();

        // Illegal opcode
        cyc("ill_idle",   1'b1, 1'b1, 6'b111111, E_IDLE);
        cyc("ill_fetch",  1'b1, 1'b1, 6'b111111, E_FETCH_R);
        cyc("ill_decode", 1'b1, 1'b1, 6'b111111, E_DECODE);
        for (int i = 0; i < 3; i++)
            cyc("ill_error", 1'b0, 1'b0, 6'b000000, E_ERROR);
        rst = 1'b1;
        #1;
        check("rst3_ctl", 32'(ctl), 32'(E_IDLE));
        release_reset();

        // beq then j, start dropped during j
        cyc("b_idle",   1'b1, 1'b1, 6'b000100, E_IDLE);
        cyc("b_fetch",  1'b1, 1'b1, 6'b000100, E_FETCH_R);
        cyc("b_decode", 1'b1, 1'b1, 6'b000100, E_DECODE);
        cyc("b_branch", 1'b1, 1'b1, 6'b000100, E_BRANCH);
        cyc("j_fetch",  1'b1, 1'b1, 6'b000010, E_FETCH_R);
        cyc("j_decode", 1'b0, 1'b1, 6'b000010, E_DECODE);
        cyc("j_jump",   1'b0, 1'b1, 6'b000010, E_JUMP);
        cyc("j_idle",   1'b0, 1'b1, 6'b000010, E_IDLE);
        check("bj_cnt", instr_cnt, 32'd2);

        // addi with two-cycle fetch stall
        cyc("a_idle",    1'b1, 1'b0, 6'b001000, E_IDLE);
        cyc("a_fetch_w", 1'b1, 1'b0, 6'b001000, E_FETCH_N);
        cyc("a_fetch_w", 1'b1, 1'b0, 6'b001000, E_FETCH_N);
        cyc("a_fetch_r", 1'b1, 1'b1, 6'b001000, E_FETCH_R);
        cyc("a_decode",  1'b1, 1'b1, 6'b001000, E_DECODE);
        cyc("a_ex",      1'b1, 1'b1, 6'b001000, E_ADDIEX);
        cyc("a_wb",      1'b0, 1'b1, 6'b001000, E_ADDIWB);
        cyc("a_idle2",   1'b0, 1'b1, 6'b001000, E_IDLE);
        check("a_cnt", instr_cnt, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
